// File: rtl/layer_buffer_pkg.sv
// Shared types and constants for the layer_buffer slice: stream FSM encoding,
// default geometry, and the helper that locates a lane inside the packed input bus.
package layer_buffer_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int DECIMAL_WIDTH   = 16;
  localparam int NUM_NEURONS_DEF = 16;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } stream_state_t;

  // Lane k occupies bits [k*width +: width] of the flattened per-layer bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/layer_buffer_if.sv
// Upstream capture lanes and downstream burst signals of layer_buffer, with
// the block's own view (slave) and the driving environment's view (master).
interface layer_buffer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_NEURONS = 16
);
  logic [NUM_NEURONS-1:0]            i_valid;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] din;
  logic                              o_valid;
  logic                              o_start;
  logic                              o_last;
  logic [DATA_WIDTH-1:0]             dout;
  logic                              busy;
  logic                              overrun;

  modport slave (
    input  i_valid, din,
    output o_valid, o_start, o_last, dout, busy, overrun
  );

  modport master (
    output i_valid, din,
    input  o_valid, o_start, o_last, dout, busy, overrun
  );
endinterface

// File: rtl/layer_buffer_relu_unit.sv
// Combinational optional ReLU on one signed fixed-point word; width is preserved.
module relu_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic signed [DATA_WIDTH-1:0] o_data
);

  function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  assign o_data = i_en ? relu(i_data) : i_data;

endmodule

// File: rtl/layer_buffer.sv
// layer_buffer: captures one layer's per-lane results into ping-pong banks and
// replays each completed bank as a gap-free NUM_NEURONS-word burst.
module layer_buffer
  import layer_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int RELU_EN     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  layer_buffer_if.slave bus
);

  localparam int             IW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_NEURONS - 1);

  logic [DATA_WIDTH-1:0]        r_bank [2][NUM_NEURONS];
  logic [1:0]                   r_full;
  logic                         r_cb;
  logic [NUM_NEURONS-1:0]       r_mask;
  logic                         r_overrun;

  stream_state_t                r_state;
  logic                         r_rb;
  logic [IW-1:0]                r_idx;
  logic                         r_valid;
  logic                         r_start;
  logic                         r_last;
  logic [DATA_WIDTH-1:0]        r_dout;

  logic signed [DATA_WIDTH-1:0] w_relu [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       w_acc;
  logic [NUM_NEURONS-1:0]       w_mask_set;
  logic                         w_drop;
  logic                         w_done;
  logic                         w_clr;
  logic                         w_other_free;
  logic [1:0]                   w_full_nxt;

  stream_state_t                w_state_nxt;
  logic                         w_rb_nxt;
  logic [IW-1:0]                w_idx_nxt;
  logic                         w_emit;
  logic                         w_valid_nxt;
  logic                         w_start_nxt;
  logic                         w_last_nxt;
  logic [DATA_WIDTH-1:0]        w_dout_nxt;

  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_lane
    relu_unit #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
      .i_en  (RELU_EN != 0),
      .i_data(bus.din[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .o_data(w_relu[k])
    );
  end

  assign w_acc        = bus.i_valid & ~r_mask;
  assign w_drop       = |(bus.i_valid & r_mask);
  assign w_mask_set   = r_mask | w_acc;
  assign w_done       = &w_mask_set;
  assign w_clr        = (r_state == S_STREAM) && (r_idx == LAST_IDX);
  // The other bank counts as free if the stream releases it on this very edge.
  assign w_other_free = !r_full[~r_cb] || (w_clr && (r_rb != r_cb));

  always_comb begin
    w_full_nxt = r_full;
    if (w_clr)  w_full_nxt[r_rb] = 1'b0;
    if (w_done) w_full_nxt[r_cb] = 1'b1;
  end

  // Capture stage: lane masks, bank ownership and drop reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full    <= '0;
      r_cb      <= 1'b0;
      r_mask    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_full    <= w_full_nxt;
      r_overrun <= w_drop;
      // A completed capture with no free partner keeps its mask saturated,
      // which turns every further lane pulse into an overrun.
      if (w_done && w_other_free) begin
        r_cb   <= ~r_cb;
        r_mask <= '0;
      end else begin
        r_mask <= w_mask_set;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (w_acc[k]) r_bank[r_cb][k] <= w_relu[k];
    end
  end

  // Stream stage: state register and registered burst outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rb    <= 1'b0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_last  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rb    <= w_rb_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_start <= w_start_nxt;
      r_last  <= w_last_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rb_nxt    = r_rb;
    w_idx_nxt   = r_idx;
    w_emit      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|r_full) begin
          w_state_nxt = S_STREAM;
          w_rb_nxt    = (&r_full) ? ~r_cb : r_full[1];
          w_idx_nxt   = '0;
          w_emit      = 1'b1;
        end
      end
      S_STREAM: begin
        if (r_idx == LAST_IDX) begin
          if (r_full[~r_rb]) begin
            w_rb_nxt  = ~r_rb;
            w_idx_nxt = '0;
            w_emit    = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_idx_nxt = r_idx + IW'(1);
          w_emit    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_valid_nxt = w_emit;
    w_start_nxt = w_emit && (w_idx_nxt == '0);
    w_last_nxt  = w_emit && (w_idx_nxt == LAST_IDX);
    w_dout_nxt  = '0;
    if (w_emit) w_dout_nxt = r_bank[w_rb_nxt][w_idx_nxt];
  end

  assign bus.o_valid = r_valid;
  assign bus.o_start = r_start;
  assign bus.o_last  = r_last;
  assign bus.dout    = r_dout;
  assign bus.busy    = (|r_full) || (|r_mask);
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_layer_buffer.sv
// Bench for layer_buffer (NUM_NEURONS=4, RELU_EN=1): random lane data against a
// queue-of-banks reference model, plus scenario-specific directed checks.
module tb_layer_buffer;

  localparam int DW = 32;
  localparam int N  = 4;
  typedef logic [N-1:0][DW-1:0] bankw_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  layer_buffer_if #(.DATA_WIDTH(DW), .NUM_NEURONS(N)) bus ();

  layer_buffer #(.DATA_WIDTH(DW), .NUM_NEURONS(N), .RELU_EN(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: completed banks wait in a FIFO (oldest streams first);
  // capture is blocked while two banks are held.
  logic [DW-1:0] m_cap [N];
  bit            m_mask [N];
  bit            m_blocked;
  bankw_t        m_q [$];
  bit            m_strm;
  int            m_pos;
  bit            m_valid, m_start, m_last, m_ovr;
  logic [DW-1:0] m_dout;

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
    return ($signed(x) < 0) ? '0 : x;
  endfunction

  function automatic bit m_busy();
    bit b;
    b = (m_q.size() != 0);
    for (int k = 0; k < N; k++) if (m_mask[k]) b = 1'b1;
    return b;
  endfunction

  task automatic model_edge(input logic [N-1:0] v, input logic [N*DW-1:0] d, input bit rst);
    int     pre;
    bit     all_set;
    bankw_t nb;
    if (rst) begin
      m_q.delete();
      m_strm = 0; m_pos = 0; m_blocked = 0;
      for (int k = 0; k < N; k++) m_mask[k] = 0;
      m_valid = 0; m_start = 0; m_last = 0; m_ovr = 0; m_dout = '0;
      return;
    end
    pre = m_q.size();
    if (!m_strm) begin
      if (pre > 0) begin m_strm = 1; m_pos = 0; end
    end else if (m_pos == N-1) begin
      void'(m_q.pop_front());
      if (pre == 2) m_pos = 0; else m_strm = 0;
    end else begin
      m_pos++;
    end
    m_valid = m_strm;
    m_start = m_strm && (m_pos == 0);
    m_last  = m_strm && (m_pos == N-1);
    m_dout  = m_strm ? m_q[0][m_pos] : '0;

    m_ovr = 0;
    for (int k = 0; k < N; k++) begin
      if (v[k]) begin
        if (m_mask[k]) m_ovr = 1;
        else begin m_mask[k] = 1; m_cap[k] = relu_ref(d[k*DW +: DW]); end
      end
    end
    all_set = 1;
    for (int k = 0; k < N; k++) if (!m_mask[k]) all_set = 0;
    if (m_blocked) begin
      if (m_q.size() < 2) begin
        m_blocked = 0;
        for (int k = 0; k < N; k++) m_mask[k] = 0;
      end
    end else if (all_set) begin
      for (int k = 0; k < N; k++) nb[k] = m_cap[k];
      m_q.push_back(nb);
      if (m_q.size() == 2) m_blocked = 1;
      else for (int k = 0; k < N; k++) m_mask[k] = 0;
    end
  endtask

  function automatic logic [DW+4:0] pack_obs();
    return {bus.o_valid, bus.o_start, bus.o_last, bus.busy, bus.overrun,
            (bus.o_valid ? bus.dout : {DW{1'b0}})};
  endfunction

  function automatic logic [DW+4:0] pack_exp();
    return {m_valid, m_start, m_last, m_busy(), m_ovr, (m_valid ? m_dout : {DW{1'b0}})};
  endfunction

  function automatic logic [N*DW-1:0] rand_din();
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic cyc(input logic [N-1:0] v, input logic [N*DW-1:0] d);
    bus.i_valid = v;
    bus.din     = d;
    @(posedge clk);
    model_edge(v, d, !rst_n);
    @(negedge clk);
    bus.i_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cyc((c == 1) ? 4'hF : 4'h0, rand_din());
      total++;
      if (pack_obs() !== '0) begin
        bad++; $display("FAIL reset_state c%0d: got %h want 0", c, pack_obs());
      end
    end
    rst_n = 1'b1;
    cyc('0, '0);
    total++;
    if (pack_obs() !== pack_exp()) begin
      bad++; $display("FAIL reset_release: got %h want %h", pack_obs(), pack_exp());
    end
  endtask

  task automatic test_all_lanes();
    logic [N*DW-1:0] d;
    logic [DW-1:0]   ew [N];
    logic [DW-1:0]   got [$];
    int              first = -1;
    d = {32'd7, 32'd0, 32'd3, -32'sd5};
    ew[0] = 32'd0; ew[1] = 32'd3; ew[2] = 32'd0; ew[3] = 32'd7;
    for (int c = 0; c < 8; c++) begin
      cyc((c == 0) ? 4'hF : 4'h0, d);
      total++;
      if (pack_obs() !== pack_exp()) begin
        bad++; $display("FAIL all_lanes_model c%0d: got %h want %h", c, pack_obs(), pack_exp());
      end
      if (bus.o_valid) begin
        if (first < 0) first = c;
        got.push_back(bus.dout);
      end
      if (c == 1) begin
        total++;
        if (bus.o_start !== 1'b1) begin bad++; $display("FAIL all_lanes_start: got %b want 1", bus.o_start); end
      end
      if (c == 4) begin
        total++;
        if (bus.o_last !== 1'b1) begin bad++; $display("FAIL all_lanes_last: got %b want 1", bus.o_last); end
      end
    end
    total++;
    if (first !== 1) begin bad++; $display("FAIL all_lanes_latency: got %0d want 1", first); end
    total++;
    if (got.size() != N) begin
      bad++; $display("FAIL all_lanes_count: got %0d want %0d", got.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== ew[i]) begin bad++; $display("FAIL all_lanes_word%0d: got %0d want %0d", i, got[i], ew[i]); end
      end
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL all_lanes_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_staggered();
    int              ord [N];
    logic [N*DW-1:0] d;
    ord[0] = 3; ord[1] = 1; ord[2] = 0; ord[3] = 2;
    d = rand_din();
    for (int c = 0; c < 10; c++) begin
      cyc((c < N) ? (4'h1 << ord[c]) : 4'h0, d);
      total++;
      if (pack_obs() !== pack_exp()) begin
        bad++; $display("FAIL stagger_model c%0d: got %h want %h", c, pack_obs(), pack_exp());
      end
      if (c < N) begin
        total++;
        if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL stagger_early c%0d: got %b want 0", c, bus.o_valid); end
      end
      if (c == N) begin
        total++;
        if ({bus.o_valid, bus.o_start, bus.dout} !== {2'b11, relu_ref(d[DW-1:0])}) begin
          bad++; $display("FAIL stagger_first: got %b%b %h want 11 %h", bus.o_valid, bus.o_start, bus.dout, relu_ref(d[DW-1:0]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int ord [N];
    int run = 0, max_run = 0, starts = 0;
    logic [N*DW-1:0] d2;
    for (int k = 0; k < N; k++) ord[k] = k;
    for (int k = N-1; k > 0; k--) begin
      int j, t;
      j = $urandom_range(k, 0); t = ord[k]; ord[k] = ord[j]; ord[j] = t;
    end
    d2 = rand_din();
    for (int c = 0; c < 14; c++) begin
      if (c == 0) cyc(4'hF, rand_din());
      else if (c <= N) cyc(4'h1 << ord[c-1], d2);
      else cyc('0, '0);
      total++;
      if (pack_obs() !== pack_exp()) begin
        bad++; $display("FAIL b2b_model c%0d: got %h want %h", c, pack_obs(), pack_exp());
      end
      run = bus.o_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (bus.o_start) starts++;
    end
    total++;
    if (max_run !== 2*N) begin bad++; $display("FAIL b2b_run: got %0d want %0d", max_run, 2*N); end
    total++;
    if (starts !== 2) begin bad++; $display("FAIL b2b_starts: got %0d want 2", starts); end
  endtask

  task automatic test_overrun_full();
    int ovr = 0, vld = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0 || c == 1 || c == 6) cyc(4'hF, rand_din());
      else if (c == 2) cyc(4'h1, rand_din());
      else if (c == 3) cyc(4'h2, rand_din());
      else cyc('0, '0);
      total++;
      if (pack_obs() !== pack_exp()) begin
        bad++; $display("FAIL ovr_model c%0d: got %h want %h", c, pack_obs(), pack_exp());
      end
      if (bus.overrun) ovr++;
      if (bus.o_valid) vld++;
    end
    total++;
    if (ovr !== 2) begin bad++; $display("FAIL ovr_pulses: got %0d want 2", ovr); end
    total++;
    if (vld !== 3*N) begin bad++; $display("FAIL ovr_words: got %0d want %0d", vld, 3*N); end
  endtask

  task automatic test_double_pulse();
    logic [N*DW-1:0] d;
    int w = 0;
    logic [DW-1:0] w1 = '0;
    for (int c = 0; c < 10; c++) begin
      d = rand_din();
      if (c == 0) begin d[DW +: DW] = 32'd9; cyc(4'b0010, d); end
      else if (c == 1) begin d[DW +: DW] = 32'd4; cyc(4'b0010, d); end
      else if (c == 2) cyc(4'b1101, d);
      else cyc('0, '0);
      total++;
      if (pack_obs() !== pack_exp()) begin
        bad++; $display("FAIL dbl_model c%0d: got %h want %h", c, pack_obs(), pack_exp());
      end
      if (c <= 1) begin
        total++;
        if (bus.overrun !== (c == 1)) begin bad++; $display("FAIL dbl_overrun c%0d: got %b want %b", c, bus.overrun, (c == 1)); end
      end
      if (bus.o_valid) begin
        if (w == 1) w1 = bus.dout;
        w++;
      end
    end
    total++;
    if (w1 !== 32'd9) begin bad++; $display("FAIL dbl_stored: got %0d want 9", w1); end
  endtask

  task automatic test_reset_mid();
    logic [N*DW-1:0] d;
    d = rand_din();
    for (int c = 0; c < 4; c++) begin
      cyc((c == 0) ? 4'hF : 4'h0, d);
      total++;
      if (pack_obs() !== pack_exp()) begin
        bad++; $display("FAIL rstmid_model c%0d: got %h want %h", c, pack_obs(), pack_exp());
      end
    end
    total++;
    if ({bus.o_valid, bus.dout} !== {1'b1, relu_ref(d[2*DW +: DW])}) begin
      bad++; $display("FAIL rstmid_word2: got %b %h want 1 %h", bus.o_valid, bus.dout, relu_ref(d[2*DW +: DW]));
    end
    rst_n = 1'b0;
    cyc('0, '0);
    total++;
    if (pack_obs() !== '0) begin bad++; $display("FAIL rstmid_clear: got %h want 0", pack_obs()); end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc('0, '0);
      total++;
      if ({bus.o_valid, bus.busy} !== 2'b00) begin
        bad++; $display("FAIL rstmid_resume c%0d: got %b%b want 00", c, bus.o_valid, bus.busy);
      end
    end
  endtask

  initial begin
    bus.i_valid = '0;
    bus.din     = '0;
    @(negedge clk);
    test_reset();
    test_all_lanes();
    test_staggered();
    test_back_to_back();
    test_overrun_full();
    test_double_pulse();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
